// File: rtl/fireboy_controller_if.sv
// Fireboy controller bus interface.
// Groups the frame/keyboard/pixel inputs and the sprite outputs of
// fireboy_controller so they travel as one port.
//   master : drives frame_clk, keycodes, DrawX/DrawY; observes sprite outputs
//   slave  : the controller itself
interface fireboy_controller_if;
  logic        frame_clk;
  logic [7:0]  keycode0;
  logic [7:0]  keycode1;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        is_Fireboy;
  logic [3:0]  Fireboy_direction;
  logic [11:0] Fireboy_address;
  logic [9:0]  Fireboy_X;
  logic [9:0]  Fireboy_Y;

  modport master (
    output frame_clk, keycode0, keycode1, DrawX, DrawY,
    input  is_Fireboy, Fireboy_direction, Fireboy_address, Fireboy_X, Fireboy_Y
  );

  modport slave (
    input  frame_clk, keycode0, keycode1, DrawX, DrawY,
    output is_Fireboy, Fireboy_direction, Fireboy_address, Fireboy_X, Fireboy_Y
  );
endinterface

// File: rtl/fireboy_controller.sv
// Fireboy motion/animation engine.
// Once per video frame (rising edge of frame_clk) updates position, jump/fall
// physics, facing, walk direction and walk animation from the keyboard.
// Per pixel, combinationally reports whether DrawX/DrawY is inside the 32x32
// sprite box and the matching 12-bit sprite ROM address.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   bus  - fireboy_controller_if.slave (frame_clk, keycodes, DrawX/Y in;
//          is_Fireboy, Fireboy_direction/address/X/Y out)
module fireboy_controller #(
  parameter int X_INIT    = 64,
  parameter int Y_FLOOR   = 416,
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 607,
  parameter int Y_MIN     = 0,
  parameter int STEP      = 2,
  parameter int JUMP_V    = 12,
  parameter int GRAVITY   = 1,
  parameter int VY_MAX    = 8,
  parameter int ANIM_DIV  = 6,
  parameter logic [7:0] KEY_LEFT  = 8'h50,
  parameter logic [7:0] KEY_RIGHT = 8'h4F,
  parameter logic [7:0] KEY_UP    = 8'h52
) (
  input  logic                 clk,
  input  logic                 rst,
  fireboy_controller_if.slave  bus
);

  typedef enum logic [1:0] {GROUND, JUMP, FALL} state_t;

  localparam logic [3:0] DIR_LEFT  = 4'd1;
  localparam logic [3:0] DIR_RIGHT = 4'd2;
  localparam logic [3:0] DIR_AIR   = 4'd3;
  localparam logic [3:0] DIR_STILL = 4'd4;

  localparam logic signed [10:0] XMIN_S   = 11'(X_MIN);
  localparam logic signed [10:0] XMAX_S   = 11'(X_MAX);
  localparam logic signed [10:0] STEP_S   = 11'(STEP);
  localparam logic signed [10:0] YMIN_S   = 11'(Y_MIN);
  localparam logic signed [10:0] YFLOOR_S = 11'(Y_FLOOR);
  localparam logic signed [7:0]  JUMP_VY  = 8'(-JUMP_V);
  localparam logic signed [7:0]  GRAV8    = 8'(GRAVITY);
  localparam logic signed [7:0]  VYMAX8   = 8'(VY_MAX);

  state_t             state_q, state_d;
  logic               frame_clk_q;
  logic               tick;
  logic [9:0]         x_q, x_d, y_q, y_d;
  logic signed [7:0]  vy_q, vy_d;
  logic [1:0]         anim_q, anim_d;
  logic [2:0]         anim_cnt_q, anim_cnt_d;
  logic               facing_left_q, facing_left_d;
  logic [3:0]         dir_q, dir_d;

  logic               key_l, key_r, key_u, move_l, move_r;
  logic signed [10:0] x_ext, x_left, x_right, y_ext, y_sum;
  logic signed [7:0]  vy_inc;

  // One-cycle pulse on the rising edge of the frame clock level.
  assign tick = bus.frame_clk & ~frame_clk_q;

  assign key_l  = (bus.keycode0 == KEY_LEFT)  || (bus.keycode1 == KEY_LEFT);
  assign key_r  = (bus.keycode0 == KEY_RIGHT) || (bus.keycode1 == KEY_RIGHT);
  assign key_u  = (bus.keycode0 == KEY_UP)    || (bus.keycode1 == KEY_UP);
  assign move_l = key_l & ~key_r;
  assign move_r = key_r & ~key_l;

  // Position math is done in 11-bit signed so a step past either edge is
  // seen as out of range instead of wrapping.
  assign x_ext   = signed'({1'b0, x_q});
  assign x_left  = x_ext - STEP_S;
  assign x_right = x_ext + STEP_S;
  assign y_ext   = signed'({1'b0, y_q});
  assign y_sum   = y_ext + signed'({{3{vy_q[7]}}, vy_q});
  assign vy_inc  = vy_q + GRAV8;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_clk_q   <= 1'b0;
      state_q       <= GROUND;
      x_q           <= 10'(X_INIT);
      y_q           <= 10'(Y_FLOOR);
      vy_q          <= '0;
      anim_q        <= '0;
      anim_cnt_q    <= '0;
      facing_left_q <= 1'b0;
      dir_q         <= DIR_STILL;
    end else begin
      frame_clk_q   <= bus.frame_clk;
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      vy_q          <= vy_d;
      anim_q        <= anim_d;
      anim_cnt_q    <= anim_cnt_d;
      facing_left_q <= facing_left_d;
      dir_q         <= dir_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    vy_d          = vy_q;
    anim_d        = anim_q;
    anim_cnt_d    = anim_cnt_q;
    facing_left_d = facing_left_q;
    dir_d         = dir_q;

    if (tick) begin
      if (move_l) begin
        facing_left_d = 1'b1;
        x_d = (x_left < XMIN_S) ? XMIN_S[9:0] : x_left[9:0];
      end else if (move_r) begin
        facing_left_d = 1'b0;
        x_d = (x_right > XMAX_S) ? XMAX_S[9:0] : x_right[9:0];
      end

      case (state_q)
        GROUND: begin
          // Takeoff only loads the velocity; Y starts moving next frame.
          if (key_u) begin
            state_d = JUMP;
            vy_d    = JUMP_VY;
          end
        end
        JUMP: begin
          if (y_sum < YMIN_S) begin
            y_d     = YMIN_S[9:0];
            vy_d    = '0;
            state_d = FALL;
          end else begin
            y_d  = y_sum[9:0];
            vy_d = vy_inc;
            if (!vy_inc[7]) state_d = FALL;
          end
        end
        FALL: begin
          if (y_sum >= YFLOOR_S) begin
            y_d     = YFLOOR_S[9:0];
            vy_d    = '0;
            state_d = GROUND;
          end else begin
            y_d  = y_sum[9:0];
            vy_d = (vy_inc > VYMAX8) ? VYMAX8 : vy_inc;
          end
        end
        default: state_d = GROUND;
      endcase

      // Direction reflects the state being entered, so takeoff reports
      // airborne on the same frame.
      if (state_d != GROUND) dir_d = DIR_AIR;
      else if (move_l)       dir_d = DIR_LEFT;
      else if (move_r)       dir_d = DIR_RIGHT;
      else                   dir_d = DIR_STILL;

      if (dir_d == DIR_LEFT || dir_d == DIR_RIGHT) begin
        if (anim_cnt_q == 3'(ANIM_DIV - 1)) begin
          anim_cnt_d = '0;
          anim_d     = anim_q + 2'd1;
        end else begin
          anim_cnt_d = anim_cnt_q + 3'd1;
        end
      end else begin
        anim_cnt_d = '0;
        anim_d     = '0;
      end
    end
  end

  // Pixel path: offsets relative to sprite top-left, mirrored when facing left.
  logic signed [10:0] ox, oy;
  logic               in_box;
  logic [4:0]         col;

  assign ox     = signed'({1'b0, bus.DrawX}) - x_ext;
  assign oy     = signed'({1'b0, bus.DrawY}) - y_ext;
  assign in_box = (ox >= 11'sd0) && (ox <= 11'sd31) && (oy >= 11'sd0) && (oy <= 11'sd31);
  assign col    = facing_left_q ? (5'd31 - ox[4:0]) : ox[4:0];

  assign bus.is_Fireboy        = in_box;
  assign bus.Fireboy_address   = in_box ? {anim_q, oy[4:0], col} : 12'd0;
  assign bus.Fireboy_direction = dir_q;
  assign bus.Fireboy_X         = x_q;
  assign bus.Fireboy_Y         = y_q;

endmodule
